// File: rtl/atmega_pio_pcint_if.sv
// CPU I/O bus plus data-space bus for the PIO/pin-change block; master drives strobes, slave returns read data.
interface atmega_pio_pcint_if #(
  parameter int BUS_ADDR_DATA_LEN = 16
);
  logic [BUS_ADDR_DATA_LEN-1:0] addr;
  logic                         wr;
  logic                         rd;
  logic [7:0]                   bus_in;
  logic [7:0]                   bus_out;
  logic [7:0]                   addr_dat;
  logic                         wr_dat;
  logic                         rd_dat;
  logic [7:0]                   bus_dat_in;
  logic [7:0]                   bus_dat_out;

  modport master (
    output addr, wr, rd, bus_in, addr_dat, wr_dat, rd_dat, bus_dat_in,
    input  bus_out, bus_dat_out
  );

  modport slave (
    input  addr, wr, rd, bus_in, addr_dat, wr_dat, rd_dat, bus_dat_in,
    output bus_out, bus_dat_out
  );
endinterface

// File: rtl/atmega_pio_pcint.sv
// GPIO port with PORT/DDR/PIN, PIN-write toggle and pin-change interrupt; writes land next edge, reads are combinational, no backpressure.
// ATMEGA_PIO_SYNC_EN adds a 2-flop input synchronizer (PIN latency 2 cycles instead of 0).
module atmega_pio_pcint #(
  parameter int         BUS_ADDR_DATA_LEN = 16,
  parameter int         WIDTH             = 8,
  parameter int         PORT_ADDR         = 0,
  parameter int         DDR_ADDR          = 1,
  parameter int         PIN_ADDR          = 2,
  parameter int         PCMSK_ADDR        = 3,
  parameter int         PCIFR_ADDR        = 4,
  parameter int         DATA_OFFSET       = 'h20,
  parameter logic [7:0] PCINT_RST_MASK    = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  atmega_pio_pcint_if.slave    bus,
  input  logic [WIDTH-1:0]     io_in,
  output logic [WIDTH-1:0]     io_out,
  output logic [WIDTH-1:0]     io_oe,
  output logic                 irq,
  input  logic                 irq_ack
);

  localparam int NREG = 5;
  // select bit order: 0 PORT, 1 DDR, 2 PIN, 3 PCMSK, 4 PCIFR
  typedef logic [NREG-1:0] sel_t;

  function automatic sel_t dec_io(input logic [BUS_ADDR_DATA_LEN-1:0] a);
    sel_t s;
    s[0] = (a == BUS_ADDR_DATA_LEN'(PORT_ADDR));
    s[1] = (a == BUS_ADDR_DATA_LEN'(DDR_ADDR));
    s[2] = (a == BUS_ADDR_DATA_LEN'(PIN_ADDR));
    s[3] = (a == BUS_ADDR_DATA_LEN'(PCMSK_ADDR));
    s[4] = (a == BUS_ADDR_DATA_LEN'(PCIFR_ADDR));
    return s;
  endfunction

  function automatic sel_t dec_dat(input logic [7:0] a);
    sel_t s;
    s[0] = (a == 8'(PORT_ADDR + DATA_OFFSET));
    s[1] = (a == 8'(DDR_ADDR + DATA_OFFSET));
    s[2] = (a == 8'(PIN_ADDR + DATA_OFFSET));
    s[3] = (a == 8'(PCMSK_ADDR + DATA_OFFSET));
    s[4] = (a == 8'(PCIFR_ADDR + DATA_OFFSET));
    return s;
  endfunction

  logic [WIDTH-1:0] port_r, ddr_r, pcmsk_r, pin_q, prev, chg, wdat;
  logic             pcif, pcif_clr;
  logic [7:0]       wdata, io_val, dat_val;
  logic [7:0]       reg_val [NREG];
  sel_t             io_sel, dat_sel, wsel;

`ifdef ATMEGA_PIO_SYNC_EN
  logic [WIDTH-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= io_in;
      sync2 <= sync1;
    end
  end

  assign pin_q = sync2;
`else
  assign pin_q = rst ? '0 : io_in;
`endif

  assign io_sel  = dec_io(bus.addr);
  assign dat_sel = dec_dat(bus.addr_dat);

  // The I/O bus wins when both buses write in the same cycle.
  assign wsel  = bus.wr ? io_sel : (bus.wr_dat ? dat_sel : '0);
  assign wdata = bus.wr ? bus.bus_in : bus.bus_dat_in;
  assign wdat  = wdata[WIDTH-1:0];

  assign chg      = (pin_q ^ prev) & pcmsk_r;
  assign pcif_clr = irq_ack | (wsel[4] & wdata[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_r  <= '0;
      ddr_r   <= '0;
      pcmsk_r <= PCINT_RST_MASK[WIDTH-1:0];
      pcif    <= 1'b0;
      prev    <= '0;
    end else begin
      prev <= pin_q;
      if (wsel[0])
        port_r <= wdat;
      else if (wsel[2])
        port_r <= port_r ^ wdat;
      if (wsel[1])
        ddr_r <= wdat;
      if (wsel[3])
        pcmsk_r <= wdat;
      // A new change beats a simultaneous clear so no edge is lost.
      if (|chg)
        pcif <= 1'b1;
      else if (pcif_clr)
        pcif <= 1'b0;
    end
  end

  assign reg_val[0] = 8'(port_r);
  assign reg_val[1] = 8'(ddr_r);
  assign reg_val[2] = 8'(pin_q);
  assign reg_val[3] = 8'(pcmsk_r);
  assign reg_val[4] = {7'b0, pcif};

  always_comb begin
    io_val  = '0;
    dat_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (io_sel[i])
        io_val = io_val | reg_val[i];
      if (dat_sel[i])
        dat_val = dat_val | reg_val[i];
    end
  end

  assign bus.bus_out     = (bus.rd && !rst) ? io_val : 8'h00;
  assign bus.bus_dat_out = (bus.rd_dat && !rst) ? dat_val : 8'h00;

  assign io_out = ddr_r & port_r;
  assign io_oe  = ddr_r;
  assign irq    = pcif;

endmodule

// File: tb/tb_atmega_pio_pcint.sv
// Directed plus randomized bench for atmega_pio_pcint against a register-level reference model.
module tb_atmega_pio_pcint;

`ifdef ATMEGA_PIO_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] io_in, io_out, io_oe;
  logic       irq, irq_ack;
  logic [2:0] io_in3, io_out3, io_oe3;
  logic       irq3;

  always #50 clk = ~clk;

  atmega_pio_pcint_if #(.BUS_ADDR_DATA_LEN(16)) bus ();
  atmega_pio_pcint_if #(.BUS_ADDR_DATA_LEN(16)) bus3 ();

  atmega_pio_pcint dut (
    .clk(clk), .rst(rst), .bus(bus), .io_in(io_in), .io_out(io_out),
    .io_oe(io_oe), .irq(irq), .irq_ack(irq_ack)
  );

  atmega_pio_pcint #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .io_in(io_in3), .io_out(io_out3),
    .io_oe(io_oe3), .irq(irq3), .irq_ack(1'b0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register values plus a history of sampled pad values.
  logic [7:0] m_port, m_ddr, m_msk, m_prev;
  logic       m_pcif;
  logic [7:0] hist [$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_pin();
    if (rst) return 8'h00;
    if (LAT == 0) return io_in;
    return hist[hist.size() - LAT];
  endfunction

  function automatic logic [7:0] exp_rd(input int a);
    if (rst) return 8'h00;
    case (a)
      0: return m_port;
      1: return m_ddr;
      2: return m_pin();
      3: return m_msk;
      4: return {7'b0, m_pcif};
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    m_port = 0; m_ddr = 0; m_msk = 0; m_pcif = 0; m_prev = 0;
    hist.delete();
    hist.push_back(8'h00);
    hist.push_back(8'h00);
  endtask

  // Advance one clock edge, updating the model from the inputs presented before it.
  task automatic tick();
    logic [7:0] pin, d, n_port, n_ddr, n_msk;
    logic       w, clr, n_pcif;
    int         a;
    pin = m_pin();
    w = 0; a = -1; d = 0;
    if (bus.wr) begin
      w = 1; a = int'(bus.addr); d = bus.bus_in;
    end else if (bus.wr_dat) begin
      w = 1; a = int'(bus.addr_dat) - 32; d = bus.bus_dat_in;
    end
    clr = irq_ack || (w && a == 4 && d[0]);
    n_pcif = (((pin ^ m_prev) & m_msk) != 0) ? 1'b1 : (m_pcif && !clr);
    n_port = m_port; n_ddr = m_ddr; n_msk = m_msk;
    if (w) begin
      case (a)
        0: n_port = d;
        1: n_ddr = d;
        2: n_port = m_port ^ d;
        3: n_msk = d;
        default: ;
      endcase
    end
    hist.push_back(io_in);
    if (hist.size() > 4) void'(hist.pop_front());
    @(posedge clk);
    #1;
    m_port = n_port; m_ddr = n_ddr; m_msk = n_msk; m_pcif = n_pcif; m_prev = pin;
  endtask

  task automatic idle();
    bus.wr = 0; bus.rd = 0; bus.wr_dat = 0; bus.rd_dat = 0; irq_ack = 0;
  endtask

  task automatic io_wr(input int a, input logic [7:0] d);
    bus.addr = 16'(a); bus.bus_in = d; bus.wr = 1;
    tick();
    bus.wr = 0;
  endtask

  task automatic dat_wr(input int a, input logic [7:0] d);
    bus.addr_dat = 8'(a + 32); bus.bus_dat_in = d; bus.wr_dat = 1;
    tick();
    bus.wr_dat = 0;
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 6; a++) begin
      bus.rd = 1; bus.addr = 16'(a);
      bus.rd_dat = 1; bus.addr_dat = 8'(a + 32);
      #1;
      chk($sformatf("%s io_rd%0d", tag, a), bus.bus_out, exp_rd(a));
      chk($sformatf("%s dat_rd%0d", tag, a), bus.bus_dat_out, exp_rd(a));
    end
    bus.rd = 0; bus.rd_dat = 0;
    chk({tag, " io_out"}, io_out, rst ? 8'h00 : (m_ddr & m_port));
    chk({tag, " io_oe"}, io_oe, rst ? 8'h00 : m_ddr);
    chk({tag, " irq"}, {7'b0, irq}, {7'b0, m_pcif});
  endtask

  initial begin
    int n;
    rst = 1; io_in = 8'h00; io_in3 = 3'b000;
    idle();
    bus.addr = 0; bus.bus_in = 0; bus.addr_dat = 0; bus.bus_dat_in = 0;
    bus3.addr = 0; bus3.bus_in = 0; bus3.addr_dat = 0; bus3.bus_dat_in = 0;
    bus3.wr = 0; bus3.rd = 0; bus3.wr_dat = 0; bus3.rd_dat = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset0");
    rst = 0;

    // Basic readback over the I/O bus and the data space.
    io_wr(1, 8'hF0);
    io_wr(0, 8'hFF);
    chk("oe_F0", io_oe, 8'hF0);
    chk("out_F0", io_out, 8'hF0);
    check_all("io_wr");
    dat_wr(1, 8'h3C);
    dat_wr(0, 8'h5A);
    check_all("dat_wr");

    // PIN-write toggle.
    io_wr(0, 8'h0F);
    io_wr(2, 8'hFF);
    chk("toggle_ff", m_port, 8'hF0);
    check_all("toggle_ff");
    io_wr(2, 8'h00);
    check_all("toggle_00");

    // Both buses write PORT in the same cycle.
    bus.addr = 16'd0; bus.bus_in = 8'h11; bus.wr = 1;
    bus.addr_dat = 8'h20; bus.bus_dat_in = 8'h22; bus.wr_dat = 1;
    tick();
    idle();
    bus.rd = 1; bus.addr = 16'd0;
    #1;
    chk("arb_port", bus.bus_out, 8'h11);
    bus.rd = 0;

    // Reset asserted in the middle of a PORT write with live pad input.
    io_in = 8'h5A;
    bus.addr = 16'd0; bus.bus_in = 8'hA5; bus.wr = 1;
    #10;
    rst = 1;
    m_reset();
    #1;
    check_all("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    idle();
    rst = 0;
    repeat (LAT + 2) tick();
    check_all("post_rst");

    // Masked pin changes are ignored; an unmasked one sets PCIF with the expected latency.
    io_wr(3, 8'h04);
    io_in[3] = ~io_in[3];
    repeat (LAT + 3) tick();
    chk("mask_ign", {7'b0, irq}, 8'h00);
    check_all("mask_ign");
    io_in[2] = ~io_in[2];
    n = 0;
    while (irq !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("pcif_latency", 8'(n), 8'(LAT + 1));
    check_all("pcif_set");

    // Change and irq_ack on the same edge: set wins.
    repeat (3) tick();
    io_in[2] = ~io_in[2];
    repeat (LAT) tick();
    irq_ack = 1;
    tick();
    irq_ack = 0;
    chk("race_keep", {7'b0, irq}, 8'h01);
    check_all("race");
    repeat (2) tick();
    irq_ack = 1;
    tick();
    irq_ack = 0;
    chk("ack_clear", {7'b0, irq}, 8'h00);
    io_in[2] = ~io_in[2];
    repeat (LAT + 1) tick();
    chk("reset_pcif", {7'b0, irq}, 8'h01);
    io_wr(4, 8'h00);
    chk("pcifr_w0", {7'b0, irq}, 8'h01);
    io_wr(4, 8'h01);
    chk("pcifr_w1", {7'b0, irq}, 8'h00);
    check_all("pcifr");

    // Randomized traffic on both buses, pads and acknowledge.
    for (int i = 0; i < 400; i++) begin
      int ra;
      bus.wr = ($urandom_range(0, 3) == 0);
      bus.wr_dat = ($urandom_range(0, 3) == 0);
      bus.addr = ($urandom_range(0, 15) == 0) ? 16'h0100 : 16'($urandom_range(0, 5));
      bus.addr_dat = 8'(30 + $urandom_range(0, 8));
      bus.bus_in = 8'($urandom);
      bus.bus_dat_in = 8'($urandom);
      irq_ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) io_in = 8'($urandom);
      ra = $urandom_range(0, 6);
      bus.rd = 1; bus.rd_dat = 1;
      bus.addr = 16'(ra); bus.addr_dat = 8'(ra + 32);
      #1;
      chk("rnd_io_rd", bus.bus_out, exp_rd(ra));
      chk("rnd_dat_rd", bus.bus_dat_out, exp_rd(ra));
      bus.rd = 0; bus.rd_dat = 0;
      bus.addr = ($urandom_range(0, 15) == 0) ? 16'h0100 : 16'($urandom_range(0, 5));
      chk("rnd_io_out", io_out, m_ddr & m_port);
      chk("rnd_io_oe", io_oe, m_ddr);
      chk("rnd_irq", {7'b0, irq}, {7'b0, m_pcif});
      tick();
    end
    idle();
    check_all("rnd_end");

    // Narrow instance: unimplemented bits read 0 and writes to them are dropped.
    bus3.addr = 16'd1; bus3.bus_in = 8'hFF; bus3.wr = 1;
    tick();
    bus3.addr = 16'd0;
    tick();
    bus3.wr = 0;
    io_in3 = 3'b101;
    repeat (LAT + 1) tick();
    bus3.rd = 1; bus3.addr = 16'd0;
    #1;
    chk("w3_port", bus3.bus_out, 8'h07);
    bus3.addr = 16'd1;
    #1;
    chk("w3_ddr", bus3.bus_out, 8'h07);
    bus3.addr = 16'd2;
    #1;
    chk("w3_pin", bus3.bus_out, 8'h05);
    bus3.rd = 0; bus3.rd_dat = 1; bus3.addr_dat = 8'h20;
    #1;
    chk("w3_dat_port", bus3.bus_dat_out, 8'h07);
    bus3.rd_dat = 0;
    chk("w3_io_out", {5'b0, io_out3}, 8'h07);
    chk("w3_io_oe", {5'b0, io_oe3}, 8'h07);
    chk("w3_irq", {7'b0, irq3}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/atmega_pio_pcint.md
Name: atmega_pio_pcint

Overview:
- Parametrised successor to the existing ATmega port block: a GPIO port of WIDTH pins (1..8) with PORT/DDR/PIN registers, PIN-write toggle, per-pin pin-change interrupt (PCMSK/PCIF), and a registered input edge detector.
- Sits on the CPU I/O bus (addr/wr/rd) and the data-space bus (addr_dat/wr_dat/rd_dat); drives io_out/io_oe to the pads and irq to the interrupt controller.

Parameters:
- BUS_ADDR_DATA_LEN, 16, I/O bus address width
- WIDTH, 8, implemented pins (1..8); bits >= WIDTH read 0, writes ignored
- PORT_ADDR, 0, I/O address of PORT
- DDR_ADDR, 1, I/O address of DDR
- PIN_ADDR, 2, I/O address of PIN
- PCMSK_ADDR, 3, I/O address of pin-change mask
- PCIFR_ADDR, 4, I/O address of flag register (bit0 = PCIF)
- DATA_OFFSET, 'h20, data-space address = I/O address + DATA_OFFSET
- PCINT_RST_MASK, 8'h00, reset value of PCMSK

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- addr  in  BUS_ADDR_DATA_LEN  I/O bus address
- wr  in  1  I/O write strobe
- rd  in  1  I/O read strobe
- bus_in  in  8  I/O write data
- bus_out  out  8  I/O read data (combinational)
- addr_dat  in  8  data-space address
- wr_dat  in  1  data-space write strobe
- rd_dat  in  1  data-space read strobe
- bus_dat_in  in  8  data-space write data
- bus_dat_out  out  8  data-space read data (combinational)
- io_in  in  WIDTH  pad inputs
- io_out  out  WIDTH  pad output value = DDR & PORT
- io_oe  out  WIDTH  pad output enable = DDR
- irq  out  1  interrupt request = PCIF
- irq_ack  in  1  one-cycle vector-taken pulse, clears PCIF

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-high. During reset: PORT=0, DDR=0, PCMSK=PCINT_RST_MASK, PCIF=0, pin_q=0, prev=0, irq=0, io_out=0, io_oe=0; bus_out and bus_dat_out read 0.
- Write arbitration: wr has priority. If wr and wr_dat are both high, only the I/O write happens (matches existing port). Writes take effect at the clock edge following the strobe.
- PORT, DDR, PCMSK: plain register writes.
- PIN write: each 1 bit toggles the matching PORT bit (PORT <= PORT ^ data). 0 bits leave PORT unchanged.
- PCIFR write: writing 1 to bit0 clears PCIF; writing 0 has no effect.
- Reads: PORT, DDR and PCMSK return the register values. PIN returns pin_q (the sampled input). PCIFR returns {7'b0, PCIF}. Unmapped addresses, or no read strobe, return 8'h00.
- Input path: pin_q is the sampled io_in (see Optional Feature). prev <= pin_q every cycle.
- Change detect: chg = (pin_q ^ prev) & PCMSK. If chg != 0, PCIF <= 1 on the next edge. Changes on masked pins are ignored.
- Simultaneous events: a set in the same cycle as a clear (PCIFR write or irq_ack) wins, so PCIF stays 1 and no edge is lost.
- Output pins: an output-driven pin still reads back through PIN and can raise PCIF.
- Reset during an operation: all state returns to reset values immediately; the first post-reset sample does not raise PCIF because prev = pin_q = 0 and the mask resets to its reset value.
- PIN latency, io_in change to PIN readable: 2 cycles with the macro, 0 cycles without. PCIF sets 1 cycle after pin_q changes.

Optional Feature:
- Macro ATMEGA_PIO_SYNC_EN.
- Defined: io_in passes through a 2-flop synchronizer (both flops reset to 0) to form pin_q. Use for asynchronous pads.
- Undefined: pin_q = io_in combinationally. Change detect still uses the registered prev. Use when io_in is already synchronous to clk.

Test Plan:
- Reset and readback: assert rst mid-write with PORT=8'hA5 → all outputs 0 and every register reads 8'h00. Write DDR=8'hF0, PORT=8'hFF → io_oe=8'hF0, io_out=8'hF0, reads return the written values. Repeat on the data space at 'h21/'h20.
- Toggle: PORT=8'h0F, write PIN=8'hFF → PORT=8'hF0. Write PIN=8'h00 → PORT unchanged.
- Arbitration: wr to PORT with 8'h11 and wr_dat to PORT with 8'h22 in the same cycle → PORT=8'h11.
- Pin change, mask: PCMSK=8'h04, toggle io_in[3] → PCIF stays 0. Toggle io_in[2] → PCIF=1, irq=1, latency 3 cycles (SYNC_EN) or 1 cycle (no macro).
- Clear race: with PCIF=1, pulse irq_ack in the same cycle a masked-in pin changes → PCIF stays 1. A lone irq_ack → PCIF=0. Writing PCIFR=8'h01 also clears it.
- WIDTH=3: write PORT=8'hFF → reads 8'h07, io_out is 3 bits, PIN bits [7:3] read 0.
